// File: rtl/shift_ctrl_pkg.sv
// rtl/shift_ctrl_pkg.sv - shared constants and helpers for the shift register control stage
package shift_ctrl_pkg;

    localparam logic [1:0] SPD_SLOW = 2'b00;
    localparam logic [1:0] SPD_MED  = 2'b01;
    localparam logic [1:0] SPD_FAST = 2'b10;
    localparam logic [1:0] SPD_MAX  = 2'b11;

    localparam logic DIR_LEFT  = 1'b1;
    localparam logic DIR_RIGHT = 1'b0;
    localparam logic SEL_RESET = DIR_LEFT;

    // Bits needed to hold values 0..max_val; never returns zero.
    function automatic int unsigned cnt_width(input int unsigned max_val);
        return (max_val > 0) ? $clog2(max_val + 1) : 1;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// rtl/btn_debounce.sv - two-flop synchronizer and stability counter for a push-button
module btn_debounce
    import shift_ctrl_pkg::*;
#(
    parameter int unsigned DB_CYCLES = 1_000_000
) (
    input  logic clock,
    input  logic i_reset,
    input  logic i_btn,
    output logic o_clean,
    output logic o_rise
);

    localparam int unsigned      NB_DB   = cnt_width(DB_CYCLES - 1);
    localparam logic [NB_DB-1:0] DB_LAST = NB_DB'(DB_CYCLES - 1);

    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic             clean_q, clean_d;
    logic [NB_DB-1:0] cnt_q, cnt_d;
    logic             accept;

    always_comb begin
        sync1_d = i_btn;
        sync2_d = sync1_q;
        clean_d = clean_q;
        cnt_d   = '0;
        accept  = 1'b0;
        // Any cycle matching the accepted level restarts the stability count.
        if (sync2_q != clean_q) begin
            if (cnt_q == DB_LAST) begin
                accept  = 1'b1;
                clean_d = sync2_q;
            end else begin
                cnt_d = cnt_q + NB_DB'(1);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (i_reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            clean_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            clean_q <= clean_d;
            cnt_q   <= cnt_d;
        end
    end

    assign o_clean = clean_q;
    assign o_rise  = accept & sync2_q;

endmodule

// File: rtl/shift_ctrl.sv
// rtl/shift_ctrl.sv - enable strobe and direction level for the rotating one-hot shift register
module shift_ctrl
    import shift_ctrl_pkg::*;
#(
    parameter int unsigned NB_COUNT  = 32,
    parameter int unsigned LIMIT0    = 50_000_000,
    parameter int unsigned LIMIT1    = 25_000_000,
    parameter int unsigned LIMIT2    = 12_500_000,
    parameter int unsigned LIMIT3    = 6_250_000,
    parameter int unsigned DB_CYCLES = 1_000_000
) (
    input  logic       clock,
    input  logic       i_reset,
    input  logic       i_run,
    input  logic [1:0] i_speed,
    input  logic       i_btn,
    output logic       o_enable,
    output logic       o_selector,
    output logic       o_btn_clean
);

    logic [NB_COUNT-1:0] cnt_q, cnt_d;
    logic [NB_COUNT-1:0] limit;
    logic                enable_q, enable_d;
    logic                selector_q, selector_d;
    logic                btn_clean;
    logic                btn_rise;

    btn_debounce #(
        .DB_CYCLES(DB_CYCLES)
    ) u_debounce (
        .clock  (clock),
        .i_reset(i_reset),
        .i_btn  (i_btn),
        .o_clean(btn_clean),
        .o_rise (btn_rise)
    );

    always_comb begin
        case (i_speed)
            SPD_SLOW: limit = NB_COUNT'(LIMIT0);
            SPD_MED:  limit = NB_COUNT'(LIMIT1);
            SPD_FAST: limit = NB_COUNT'(LIMIT2);
            default:  limit = NB_COUNT'(LIMIT3);
        endcase
    end

    // >= so that switching to a shorter period mid-count wraps at once.
    always_comb begin
        cnt_d    = '0;
        enable_d = 1'b0;
        if (i_run) begin
            if (cnt_q >= limit - NB_COUNT'(1)) begin
                enable_d = 1'b1;
            end else begin
                cnt_d = cnt_q + NB_COUNT'(1);
            end
        end
    end

    always_comb begin
        selector_d = selector_q ^ btn_rise;
    end

    always_ff @(posedge clock) begin
        if (i_reset) begin
            cnt_q      <= '0;
            enable_q   <= 1'b0;
            selector_q <= SEL_RESET;
        end else begin
            cnt_q      <= cnt_d;
            enable_q   <= enable_d;
            selector_q <= selector_d;
        end
    end

    assign o_enable    = enable_q;
    assign o_selector  = selector_q;
    assign o_btn_clean = btn_clean;

endmodule

// File: tb/tb_shift_ctrl.sv
// tb/tb_shift_ctrl.sv - self-checking bench for shift_ctrl
module tb_shift_ctrl;

    localparam int L0 = 4;
    localparam int L1 = 8;
    localparam int L2 = 2;
    localparam int L3 = 1;
    localparam int DB = 3;

    logic       clock = 1'b0;
    logic       i_reset;
    logic       i_run;
    logic [1:0] i_speed;
    logic       i_btn;
    logic       o_enable;
    logic       o_selector;
    logic       o_btn_clean;

    int checks   = 0;
    int failures = 0;

    always #5 clock = ~clock;

    shift_ctrl #(
        .NB_COUNT (32),
        .LIMIT0   (L0),
        .LIMIT1   (L1),
        .LIMIT2   (L2),
        .LIMIT3   (L3),
        .DB_CYCLES(DB)
    ) dut (
        .clock      (clock),
        .i_reset    (i_reset),
        .i_run      (i_run),
        .i_speed    (i_speed),
        .i_btn      (i_btn),
        .o_enable   (o_enable),
        .o_selector (o_selector),
        .o_btn_clean(o_btn_clean)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(negedge clock);
    endtask

    // Behavioural model: strobe after `limit` consecutive running edges,
    // clean level follows the 2-edge-delayed button once DB consecutive
    // delayed samples all disagree with it.
    int  lims[4] = '{L0, L1, L2, L3};
    bit  m_valid = 1'b0;
    bit  m_en, m_sel, m_clean;
    int  m_phase;
    bit  pipe0, pipe1;
    bit  win[$];

    always @(posedge clock) begin
        if (i_reset) begin
            m_valid = 1'b1;
            m_en    = 1'b0;
            m_sel   = 1'b1;
            m_clean = 1'b0;
            m_phase = 0;
            pipe0   = 1'b0;
            pipe1   = 1'b0;
            win.delete();
        end else if (m_valid) begin
            bit s;
            bit all_diff;
            if (!i_run) begin
                m_phase = 0;
                m_en    = 1'b0;
            end else begin
                m_phase++;
                m_en = (m_phase >= lims[i_speed]);
                if (m_en) m_phase = 0;
            end
            s = pipe1;
            win.push_back(s);
            if (win.size() > DB) void'(win.pop_front());
            all_diff = (win.size() == DB);
            foreach (win[i]) if (win[i] == m_clean) all_diff = 1'b0;
            if (all_diff) begin
                if (s && !m_clean) m_sel = !m_sel;
                m_clean = s;
            end
            pipe1 = pipe0;
            pipe0 = i_btn;
        end
    end

    always @(negedge clock) begin
        if (m_valid) begin
            chk("model_enable", o_enable, m_en);
            chk("model_selector", o_selector, m_sel);
            chk("model_btn_clean", o_btn_clean, m_clean);
        end
    end

    initial begin
        int n;
        int cnt;
        int bad;
        int first;
        int toggles;
        logic sel_at;
        logic prev_sel;
        bit pat[5];
        pat = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};

        i_reset = 1'b1;
        i_run   = 1'b1;
        i_speed = 2'b11;
        i_btn   = 1'b1;
        tick();
        chk("rst1_enable", o_enable, 0);
        chk("rst1_selector", o_selector, 1);
        tick();
        chk("rst_enable", o_enable, 0);
        chk("rst_selector", o_selector, 1);
        chk("rst_clean", o_btn_clean, 0);

        i_reset = 1'b0;
        i_btn   = 1'b0;
        i_speed = 2'b00;
        n = 0;
        do begin tick(); n++; end while (!o_enable && n < 20);
        chk("first_strobe_cycle", n, 4);

        cnt = 0; bad = 0;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (o_enable) begin
                cnt++;
                if (i % 4 != 0) bad++;
            end
        end
        chk("strobe_count", cnt, 5);
        chk("strobe_spacing", bad, 0);

        i_speed = 2'b11;
        cnt = 0;
        repeat (6) begin tick(); if (o_enable) cnt++; end
        chk("max_speed_high", cnt, 6);

        i_speed = 2'b01;
        cnt = 0;
        repeat (6) begin tick(); if (o_enable) cnt++; end
        chk("med_no_strobe", cnt, 0);
        i_speed = 2'b10;
        tick();
        chk("fast_wrap", o_enable, 1);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("fast_period", o_enable, i % 2);
        end

        i_run = 1'b0;
        i_speed = 2'b00;
        tick();
        i_run = 1'b1;
        tick();
        tick();
        i_run = 1'b0;
        cnt = 0;
        repeat (5) begin tick(); if (o_enable) cnt++; end
        chk("run_low_quiet", cnt, 0);
        i_run = 1'b1;
        n = 0;
        do begin tick(); n++; end while (!o_enable && n < 20);
        chk("rerun_strobe_cycle", n, 4);

        i_run = 1'b0;
        tick();
        first = 0; bad = 0; sel_at = 1'b1;
        for (int i = 1; i <= 14; i++) begin
            i_btn = (i <= 5) ? pat[i-1] : 1'b1;
            tick();
            if (o_btn_clean && first == 0) begin
                first  = i;
                sel_at = o_selector;
            end
            if (first == 0 && o_selector !== 1'b1) bad++;
        end
        chk("bounce_accept_cycle", first, 10);
        chk("bounce_sel_hold", bad, 0);
        chk("bounce_sel_toggled", sel_at, 0);

        toggles = 0;
        prev_sel = o_selector;
        for (int i = 0; i < 20; i++) begin
            i_btn = (i < 10) ? 1'b1 : 1'b0;
            tick();
            if (o_selector !== prev_sel) toggles++;
            prev_sel = o_selector;
        end
        chk("no_extra_toggle", toggles, 0);
        chk("release_clean", o_btn_clean, 0);
        chk("release_sel", o_selector, 0);

        i_run = 1'b0;
        tick();
        i_run = 1'b1;
        i_speed = 2'b10;
        tick();
        i_btn = 1'b1;
        n = 0;
        do begin tick(); n++; end while (!o_btn_clean && n < 20);
        chk("collide_cycle", n, 5);
        chk("collide_enable", o_enable, 1);
        chk("collide_sel", o_selector, 1);

        i_btn = 1'b0;
        repeat (8) tick();
        i_btn = 1'b1;
        repeat (3) tick();
        chk("pre_reset_clean", o_btn_clean, 0);
        i_reset = 1'b1;
        tick();
        chk("midreset_clean", o_btn_clean, 0);
        chk("midreset_sel", o_selector, 1);
        chk("midreset_enable", o_enable, 0);
        i_reset = 1'b0;
        n = 0;
        do begin tick(); n++; end while (!o_btn_clean && n < 20);
        chk("post_reset_accept", n, 5);
        chk("post_reset_sel", o_selector, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
